bicubic_tap_sequencer: RTL and testbench

Front-end sequencer of the bicubic resize datapath. Per frame it walks every output pixel (i, j) of the fixed 2^OUT_LOG2 × 2^OUT_LOG2 output image. For each pixel it walks the 16 neighbourhood taps (m, n ∈ {−1, 0, 1, 2}). Each tap is issued on a valid/ready stream carrying the fields the weight stage needs (i, j, m, n, x_ratio, y_ratio, x_old, y_old) plus clamped source-pixel coordinates for the line-buffer fetch.

---
 rtl/bicubic_tap_sequencer.sv | 184 ++++++++++++++++++
 tb/tb_bicubic_tap_sequencer.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/bicubic_tap_sequencer.sv
// Bicubic resize front-end: walks every output pixel of a fixed square
// output image and issues its 16 neighbourhood taps on a valid/ready stream.
// Source coordinates are tracked with running accumulators, so there is no multiplier.
module bicubic_tap_sequencer #(
    parameter int unsigned SHIFT_AMOUNT = 8,
    parameter int unsigned OUT_LOG2     = 7,
    parameter int unsigned DIM_W        = 16
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    start,
    input  logic [DIM_W-1:0]        in_rows,
    input  logic [DIM_W-1:0]        in_cols,
    output logic                    tap_valid,
    input  logic                    tap_ready,
    output logic signed [31:0]      i,
    output logic signed [31:0]      j,
    output logic signed [31:0]      m,
    output logic signed [31:0]      n,
    output logic signed [31:0]      x_ratio,
    output logic signed [31:0]      y_ratio,
    output logic signed [31:0]      x_old,
    output logic signed [31:0]      y_old,
    output logic [DIM_W-1:0]        src_row,
    output logic [DIM_W-1:0]        src_col,
    output logic                    first_tap,
    output logic                    last_tap,
    output logic                    busy,
    output logic                    done
);

    localparam int unsigned RatioShift = SHIFT_AMOUNT - OUT_LOG2;
    localparam logic signed [31:0] LastIdx = 32'(2 ** OUT_LOG2 - 1);

    typedef enum logic [1:0] {StIdle, StLoad, StRun, StDone} state_e;

    state_e             state_q, state_d;
    logic [DIM_W-1:0]   rows_q, rows_d, cols_q, cols_d;
    logic signed [31:0] x_ratio_q, x_ratio_d, y_ratio_q, y_ratio_d;
    logic signed [31:0] i_q, i_d, j_q, j_d, m_q, m_d, n_q, n_d;
    logic signed [31:0] acc_x_q, acc_x_d, acc_y_q, acc_y_d;

    // Clamp a signed coordinate into [0, dim-1]
    function automatic logic [DIM_W-1:0] clamp_dim(input logic signed [31:0] s,
                                                   input logic [DIM_W-1:0]   d);
        logic signed [31:0] d_ext;
        d_ext = $signed({{(32 - DIM_W){1'b0}}, d});
        if (s < 32'sd0) begin
            return '0;
        end else if (s >= d_ext) begin
            return d - DIM_W'(1);
        end else begin
            return s[DIM_W-1:0];
        end
    endfunction

    // Next-state logic: frame control plus the n -> m -> j -> i tap walk
    always_comb begin
        state_d   = state_q;
        rows_d    = rows_q;
        cols_d    = cols_q;
        x_ratio_d = x_ratio_q;
        y_ratio_d = y_ratio_q;
        i_d       = i_q;
        j_d       = j_q;
        m_d       = m_q;
        n_d       = n_q;
        acc_x_d   = acc_x_q;
        acc_y_d   = acc_y_q;
        unique case (state_q)
            StIdle: begin
                if (start) begin
                    state_d   = StLoad;
                    rows_d    = in_rows;
                    cols_d    = in_cols;
                    x_ratio_d = $signed({{(32 - DIM_W){1'b0}}, in_cols}) <<< RatioShift;
                    y_ratio_d = $signed({{(32 - DIM_W){1'b0}}, in_rows}) <<< RatioShift;
                end
            end
            StLoad: begin
                if (rows_q == '0 || cols_q == '0) begin
                    state_d = StDone;
                end else begin
                    state_d = StRun;
                    i_d     = 32'sd0;
                    j_d     = 32'sd0;
                    m_d     = -32'sd1;
                    n_d     = -32'sd1;
                    acc_x_d = 32'sd0;
                    acc_y_d = 32'sd0;
                end
            end
            StRun: begin
                if (tap_ready) begin
                    if (n_q != 32'sd2) begin
                        n_d = n_q + 32'sd1;
                    end else begin
                        n_d = -32'sd1;
                        if (m_q != 32'sd2) begin
                            m_d = m_q + 32'sd1;
                        end else begin
                            m_d = -32'sd1;
                            if (j_q != LastIdx) begin
                                j_d     = j_q + 32'sd1;
                                acc_x_d = acc_x_q + x_ratio_q;
                            end else begin
                                j_d     = 32'sd0;
                                acc_x_d = 32'sd0;
                                if (i_q != LastIdx) begin
                                    i_d     = i_q + 32'sd1;
                                    acc_y_d = acc_y_q + y_ratio_q;
                                end else begin
                                    state_d = StDone;
                                end
                            end
                        end
                    end
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // State and tap-field registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= StIdle;
            rows_q    <= '0;
            cols_q    <= '0;
            x_ratio_q <= '0;
            y_ratio_q <= '0;
            i_q       <= '0;
            j_q       <= '0;
            m_q       <= '0;
            n_q       <= '0;
            acc_x_q   <= '0;
            acc_y_q   <= '0;
        end else begin
            state_q   <= state_d;
            rows_q    <= rows_d;
            cols_q    <= cols_d;
            x_ratio_q <= x_ratio_d;
            y_ratio_q <= y_ratio_d;
            i_q       <= i_d;
            j_q       <= j_d;
            m_q       <= m_d;
            n_q       <= n_d;
            acc_x_q   <= acc_x_d;
            acc_y_q   <= acc_y_d;
        end
    end

    // Outputs decoded from registered state only (no path from tap_ready)
    always_comb begin
        tap_valid = (state_q == StRun);
        busy      = (state_q == StLoad) || (state_q == StRun);
        done      = (state_q == StDone);
        i         = i_q;
        j         = j_q;
        m         = m_q;
        n         = n_q;
        x_ratio   = x_ratio_q;
        y_ratio   = y_ratio_q;
        x_old     = acc_x_q >>> SHIFT_AMOUNT;
        y_old     = acc_y_q >>> SHIFT_AMOUNT;
        src_row   = '0;
        src_col   = '0;
        first_tap = 1'b0;
        last_tap  = 1'b0;
        // Clamped coordinates are only meaningful while a tap is on the bus
        if (tap_valid) begin
            src_row   = clamp_dim(y_old + m_q, rows_q);
            src_col   = clamp_dim(x_old + n_q, cols_q);
            first_tap = (m_q == -32'sd1) && (n_q == -32'sd1);
            last_tap  = (m_q == 32'sd2) && (n_q == 32'sd2);
        end
    end

endmodule

// File: tb/tb_bicubic_tap_sequencer.sv
// Self-checking bench: a full-size instance for field values at selected taps,
// and a small instance (8x8 output) for complete frames, backpressure and reset.
module tb_bicubic_tap_sequencer;

    localparam int SH = 8;
    localparam int NB = 3;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // Full-size instance signals
    logic rst_n_a, start_a, ready_a;
    logic [15:0] rows_a, cols_a;
    logic valid_a, first_a, last_a, busy_a, done_a;
    logic signed [31:0] i_a, j_a, m_a, n_a, xr_a, yr_a, xo_a, yo_a;
    logic [15:0] sr_a, sc_a;

    // Small instance signals
    logic rst_n_b, start_b, ready_b;
    logic [15:0] rows_b, cols_b;
    logic valid_b, first_b, last_b, busy_b, done_b;
    logic signed [31:0] i_b, j_b, m_b, n_b, xr_b, yr_b, xo_b, yo_b;
    logic [15:0] sr_b, sc_b;

    int vectors = 0;
    int errors  = 0;

    bicubic_tap_sequencer u_big (
        .clk(clk), .rst_n(rst_n_a), .start(start_a), .in_rows(rows_a), .in_cols(cols_a),
        .tap_valid(valid_a), .tap_ready(ready_a), .i(i_a), .j(j_a), .m(m_a), .n(n_a),
        .x_ratio(xr_a), .y_ratio(yr_a), .x_old(xo_a), .y_old(yo_a),
        .src_row(sr_a), .src_col(sc_a), .first_tap(first_a), .last_tap(last_a),
        .busy(busy_a), .done(done_a)
    );

    bicubic_tap_sequencer #(.SHIFT_AMOUNT(SH), .OUT_LOG2(NB), .DIM_W(16)) u_small (
        .clk(clk), .rst_n(rst_n_b), .start(start_b), .in_rows(rows_b), .in_cols(cols_b),
        .tap_valid(valid_b), .tap_ready(ready_b), .i(i_b), .j(j_b), .m(m_b), .n(n_b),
        .x_ratio(xr_b), .y_ratio(yr_b), .x_old(xo_b), .y_old(yo_b),
        .src_row(sr_b), .src_col(sc_b), .first_tap(first_b), .last_tap(last_b),
        .busy(busy_b), .done(done_b)
    );

    typedef struct {
        int rows, cols, k;
        int i, j, m, n, xo, yo, xr, yr, sr, sc;
        bit f, l;
    } vec_t;

    vec_t tbl[$];

    task automatic check(input string name, input logic [319:0] act, input logic [319:0] exp);
        vectors++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [319:0] pk(input int i, j, m, n, xo, yo, xr, yr, sr, sc,
                                        input bit f, l, v, b, d);
        return 320'({32'(i), 32'(j), 32'(m), 32'(n), 32'(xo), 32'(yo), 32'(xr), 32'(yr),
                      16'(sr), 16'(sc), f, l, v, b, d});
    endfunction

    function automatic logic [319:0] pack_a();
        return 320'({i_a, j_a, m_a, n_a, xo_a, yo_a, xr_a, yr_a, sr_a, sc_a,
                      first_a, last_a, valid_a, busy_a, done_a});
    endfunction

    function automatic logic [319:0] pack_b();
        return 320'({i_b, j_b, m_b, n_b, xo_b, yo_b, xr_b, yr_b, sr_b, sc_b,
                      first_b, last_b, valid_b, busy_b, done_b});
    endfunction

    function automatic int clampd(input int s, input int d);
        if (s < 0) return 0;
        if (s >= d) return d - 1;
        return s;
    endfunction

    // Reference for tap number t of a small-instance frame (uses multiplication)
    function automatic logic [319:0] model_b(input int t, rows, cols);
        int nn, xr, yr, ii, jj, mm, nv, xo, yo;
        nn = 1 << NB;
        xr = cols << (SH - NB);
        yr = rows << (SH - NB);
        nv = t % 4 - 1;
        mm = (t / 4) % 4 - 1;
        jj = (t / 16) % nn;
        ii = t / (16 * nn);
        xo = (jj * xr) >> SH;
        yo = (ii * yr) >> SH;
        return pk(ii, jj, mm, nv, xo, yo, xr, yr, clampd(yo + mm, rows), clampd(xo + nv, cols),
                  (t % 16) == 0, (t % 16) == 15, 1'b1, 1'b1, 1'b0);
    endfunction

    // Reset the big instance, start a frame, and stop with tap k on the bus
    task automatic run_a(input int rows, cols, k, output bit ok);
        int cnt;
        rst_n_a = 1'b0; start_a = 1'b0; ready_a = 1'b0;
        @(negedge clk);
        rst_n_a = 1'b1;
        rows_a = 16'(rows); cols_a = 16'(cols); start_a = 1'b1;
        @(negedge clk);
        start_a = 1'b0;
        cnt = 0;
        ok  = 1'b0;
        for (int c = 0; c < k + 10; c++) begin
            @(negedge clk);
            if (valid_a) begin
                if (cnt == k) begin
                    ready_a = 1'b0;
                    ok = 1'b1;
                    break;
                end
                ready_a = 1'b1;
                cnt++;
            end else begin
                ready_a = 1'b0;
            end
        end
    endtask

    // Run one full small-instance frame, checking every handshake against the model
    task automatic frame_b(input int rows, cols, input bit rnd, input bit poke);
        int nn, total, cnt, post;
        logic [319:0] prev;
        bit stalled, finished;
        nn = 1 << NB;
        total = nn * nn * 16;
        rows_b = 16'(rows); cols_b = 16'(cols); start_b = 1'b1; ready_b = 1'b0;
        @(negedge clk);
        start_b = 1'b0;
        cnt = 0; post = 0; stalled = 1'b0; finished = 1'b0;
        for (int c = 0; c < total * 4 + 20 && !finished; c++) begin
            @(negedge clk);
            start_b = 1'b0;
            if (stalled) check("stall_hold", pack_b(), prev);
            stalled = 1'b0;
            if (cnt == total) begin
                post++;
                ready_b = 1'b0;
                if (post == 1) begin
                    check("frame_end_done", 320'({valid_b, busy_b, done_b}), 320'(3'b001));
                end else begin
                    check("after_done_idle", 320'({valid_b, busy_b, done_b}), 320'(3'b000));
                    finished = 1'b1;
                end
            end else if (valid_b) begin
                ready_b = rnd ? ($urandom_range(0, 2) != 0) : 1'b1;
                if (ready_b) begin
                    check($sformatf("tap%0d", cnt), pack_b(), model_b(cnt, rows, cols));
                    cnt++;
                end else begin
                    stalled = 1'b1;
                    prev = pack_b();
                end
            end else begin
                ready_b = 1'b0;
                check("load_cycle", 320'({busy_b, done_b}), 320'(2'b10));
            end
            if (poke && cnt == 100) begin
                start_b = 1'b1; rows_b = 16'd3; cols_b = 16'd3;
            end
        end
        if (!finished) begin
            vectors++; errors++;
            $display("FAIL frame_timeout: got %0d handshakes expected %0d", cnt, total);
        end
    endtask

    initial begin
        bit ok;
        rst_n_a = 1'b0; start_a = 1'b0; ready_a = 1'b0; rows_a = '0; cols_a = '0;
        rst_n_b = 1'b0; start_b = 1'b0; ready_b = 1'b0; rows_b = '0; cols_b = '0;
        repeat (2) @(negedge clk);
        check("reset_big", pack_a(), '0);
        check("reset_small", pack_b(), '0);
        rst_n_b = 1'b1;

        //             rows cols k     i  j    m   n   xo  yo xr   yr   sr sc  f  l
        tbl.push_back('{256, 256, 0,    0, 0,   -1, -1, 0,  0, 512, 512, 0, 0,  1, 0});
        tbl.push_back('{256, 256, 15,   0, 0,   2,  2,  0,  0, 512, 512, 2, 2,  0, 1});
        tbl.push_back('{256, 256, 16,   0, 1,   -1, -1, 2,  0, 512, 512, 0, 1,  1, 0});
        tbl.push_back('{256, 100, 48,   0, 3,   -1, -1, 2,  0, 200, 512, 0, 1,  1, 0});
        tbl.push_back('{256, 100, 2035, 0, 127, -1, 2,  99, 0, 200, 512, 0, 99, 0, 0});
        tbl.push_back('{256, 100, 2047, 0, 127, 2,  2,  99, 0, 200, 512, 2, 99, 0, 1});
        tbl.push_back('{256, 100, 2048, 1, 0,   -1, -1, 0,  2, 200, 512, 1, 0,  1, 0});
        tbl.push_back('{1,   1,   15,   0, 0,   2,  2,  0,  0, 2,   2,   0, 0,  0, 1});
        tbl.push_back('{256, 300, 90,   0, 5,   1,  1,  11, 0, 600, 512, 1, 12, 0, 0});
        tbl.push_back('{256, 256, 2053, 1, 0,   0,  0,  0,  2, 512, 512, 2, 0,  0, 0});

        foreach (tbl[v]) begin
            run_a(tbl[v].rows, tbl[v].cols, tbl[v].k, ok);
            if (ok) begin
                check($sformatf("vec%0d", v), pack_a(),
                      pk(tbl[v].i, tbl[v].j, tbl[v].m, tbl[v].n, tbl[v].xo, tbl[v].yo,
                         tbl[v].xr, tbl[v].yr, tbl[v].sr, tbl[v].sc, tbl[v].f, tbl[v].l,
                         1'b1, 1'b1, 1'b0));
            end else begin
                vectors++; errors++;
                $display("FAIL vec%0d_timeout: got no tap %0d expected one", v, tbl[v].k);
            end
        end

        // Start latency: LOAD in cycle 1, first tap in cycle 2
        rst_n_a = 1'b0; @(negedge clk); rst_n_a = 1'b1;
        rows_a = 16'd256; cols_a = 16'd256; start_a = 1'b1;
        @(negedge clk);
        start_a = 1'b0;
        check("cycle1_load", 320'({valid_a, busy_a, done_a}), 320'(3'b010));
        @(negedge clk);
        check("cycle2_first", 320'({valid_a, busy_a, done_a, first_a}), 320'(4'b1101));

        // Zero-height frame: one busy cycle then done, no taps
        rst_n_a = 1'b0; @(negedge clk); rst_n_a = 1'b1;
        rows_a = 16'd0; cols_a = 16'd5; start_a = 1'b1;
        @(negedge clk);
        start_a = 1'b0;
        check("zero_load", 320'({valid_a, busy_a, done_a}), 320'(3'b010));
        @(negedge clk);
        check("zero_done", 320'({valid_a, busy_a, done_a}), 320'(3'b001));
        @(negedge clk);
        check("zero_idle", 320'({valid_a, busy_a, done_a}), 320'(3'b000));

        // Full frames on the small instance
        frame_b(20, 7, 1'b0, 1'b1);
        frame_b(20, 7, 1'b1, 1'b0);

        // Reset mid-frame, then a clean frame
        rows_b = 16'd20; cols_b = 16'd7; start_b = 1'b1;
        @(negedge clk);
        start_b = 1'b0; ready_b = 1'b1;
        repeat (300) @(negedge clk);
        #2 rst_n_b = 1'b0;
        #1 check("reset_mid_frame", pack_b(), '0);
        @(negedge clk);
        rst_n_b = 1'b1; ready_b = 1'b0;
        repeat (3) begin
            @(negedge clk);
            check("post_reset_quiet", 320'({valid_b, busy_b, done_b}), '0);
        end
        frame_b(5, 40, 1'b0, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
